// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - ss_state_t        : controller state encoding (IDLE, RUN, DONE)
//     - SS_DEFAULT_WIDTH  : default operand length in bits
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int SS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ss_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational subtractor cell: computes a - b - bin.
//   Ports:
//     a, b  : minuend / subtrahend bit
//     bin   : incoming borrow
//     diff  : difference bit
//     bout  : outgoing borrow
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor, LSB first. A start pulse in IDLE opens an
//   operation; WIDTH qualified bit pairs are then accepted (gaps allowed) and
//   the result is presented for one cycle in DONE.
//
//   Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output
//   (two's-complement overflow of the completed subtraction).
//
//   Parameters:
//     WIDTH       operand length in bits (2..32)
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous active-high reset
//     start       one-cycle request to begin (honoured in IDLE only)
//     bit_valid   qualifies a_bit / b_bit (honoured in RUN only)
//     a_bit,b_bit minuend / subtrahend bits, LSB first
//     busy        high while in RUN
//     diff_bit    registered difference bit
//     diff_valid  one-cycle strobe for diff_bit
//     diff_word   assembled difference, held after DONE
//     borrow_out  final borrow (1 = a < b unsigned), held after DONE
//     done        one-cycle completion pulse
//     ovf         (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow, held
//
//   state | meaning
//   IDLE  | waiting for start; results of last operation held
//   RUN   | accepting bit pairs on bit_valid
//   DONE  | one-cycle completion, done asserted
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic [WIDTH-1:0] diff_word,
    output logic             borrow_out,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ss_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             diff_bit_q, diff_bit_d;
    logic             diff_valid_q, diff_valid_d;
    logic [WIDTH-1:0] diff_word_q, diff_word_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fs_diff;
    logic fs_bout;

    full_subtractor u_fs (
        .a    (a_bit),
        .b    (b_bit),
        .bin  (borrow_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        diff_bit_d   = diff_bit_q;
        diff_valid_d = 1'b0;
        diff_word_d  = diff_word_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d        = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    borrow_d     = 1'b0;
                    diff_word_d  = '0;
                    borrow_out_d = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d        = 1'b0;
`endif
                end
            end
            RUN: begin
                if (bit_valid) begin
                    diff_bit_d   = fs_diff;
                    diff_valid_d = 1'b1;
                    borrow_d     = fs_bout;
                    diff_word_d  = {fs_diff, diff_word_q[WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        // Final pair: latch result flags; counter stays put.
                        state_d      = DONE;
                        borrow_out_d = fs_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_d        = (a_bit ^ b_bit) & (a_bit ^ fs_diff);
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            diff_bit_q   <= 1'b0;
            diff_valid_q <= 1'b0;
            diff_word_q  <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            diff_bit_q   <= diff_bit_d;
            diff_valid_q <= diff_valid_d;
            diff_word_q  <= diff_word_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff_bit   = diff_bit_q;
    assign diff_valid = diff_valid_q;
    assign diff_word  = diff_word_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor at WIDTH=8. Inputs change 1 ns after
//   the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bit_valid;
    logic         a_bit;
    logic         b_bit;
    logic         busy;
    logic         diff_bit;
    logic         diff_valid;
    logic [W-1:0] diff_word;
    logic         borrow_out;
    logic         done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_valid  (bit_valid),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .busy       (busy),
        .diff_bit   (diff_bit),
        .diff_valid (diff_valid),
        .diff_word  (diff_word),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        .ovf        (ovf),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Full operation: optional idle gaps between bits, optional start pulse
    // alongside the 4th bit, optional start held during DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic gaps, input logic poke,
                          input logic [W-1:0] exp_word, input logic exp_borrow,
                          input logic exp_ovf);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("word_cleared", {24'd0, diff_word}, 32'd0);
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1;
            a_bit     = a[i];
            b_bit     = b[i];
            start     = poke && (i == 3);
            step();
            start = 1'b0;
            chk($sformatf("dv_bit%0d", i), {31'd0, diff_valid}, 32'd1);
            chk($sformatf("dbit%0d", i), {31'd0, diff_bit}, {31'd0, exp_word[i]});
            if (i < W - 1) begin
                chk($sformatf("no_done_bit%0d", i), {31'd0, done}, 32'd0);
                if (gaps) begin
                    bit_valid = 1'b0;
                    a_bit     = ~a_bit;
                    b_bit     = ~b_bit;
                    step();
                    chk($sformatf("gap_dv%0d", i), {31'd0, diff_valid}, 32'd0);
                    chk($sformatf("gap_busy%0d", i), {31'd0, busy}, 32'd1);
                end
            end
        end
        bit_valid = 1'b0;
        chk("done", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("word", {24'd0, diff_word}, {24'd0, exp_word});
        chk("borrow", {31'd0, borrow_out}, {31'd0, exp_borrow});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) chk("ovf_unused", 32'd0, 32'd1);
`endif
        start = poke;
        step();
        start = 1'b0;
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("word_hold", {24'd0, diff_word}, {24'd0, exp_word});
        chk("borrow_hold", {31'd0, borrow_out}, {31'd0, exp_borrow});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf_hold", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_word", {24'd0, diff_word}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        chk("rst_dv", {31'd0, diff_valid}, 32'd0);
        rst = 1'b0;

        // bit_valid in IDLE is ignored
        bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        step();
        chk("idle_bv_busy", {31'd0, busy}, 32'd0);
        chk("idle_bv_dv", {31'd0, diff_valid}, 32'd0);
        chk("idle_bv_word", {24'd0, diff_word}, 32'd0);
        bit_valid = 1'b0;
        step();

        // 0x05 - 0x03 = 0x02, no borrow
        run_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        // 0x03 - 0x05 = 0xFE, borrow; bit stream 0,1,1,1,1,1,1,1
        run_op(8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
        // 0x80 - 0x01 with gaps = 0x7F, signed overflow
        run_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1);
        // start pulses in RUN and DONE ignored: 0x3C - 0x5A = 0xE2, borrow
        run_op(8'h3C, 8'h5A, 1'b0, 1'b1, 8'hE2, 1'b1, 1'b0);

        // abort 0xFF - 0x00 after 4 bits
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            step();
        end
        chk("pre_abort_dbit", {31'd0, diff_bit}, 32'd1);
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_dbit", {31'd0, diff_bit}, 32'd0);
        chk("abort_dv", {31'd0, diff_valid}, 32'd0);
        chk("abort_word", {24'd0, diff_word}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("abort_no_done%0d", i), {31'd0, done}, 32'd0);
        end
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
